mul_client: RTL and testbench



---
 rtl/mul_client_pkg.sv | 18 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/mul_client.sv | 128 ++++++++++++
 tb/tb_mul_client.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_client_pkg.sv
// Shared types and defaults for the multiplier requester/consumer client.
package mul_client_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned LAT_W_DEF = 8;

   // Client control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ERR   = 2'd3
   } state_t;

   typedef logic [WIDTH_DEF-1:0]   operand_t;
   typedef logic [2*WIDTH_DEF-1:0] product_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
module sync_fifo #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] head,
   output logic          full,
   output logic          empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage, pointers (wrap naturally for power-of-2 depth) and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/mul_client.sv
// Requester/consumer for a val/ready sequential multiplier: queues operand
// pairs, issues one at a time, captures each product with its latency.
module mul_client
   import mul_client_pkg::*;
#(
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned LAT_W   = LAT_W_DEF,
   parameter int unsigned TIMEOUT = 200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               mul_src_val,
   input  logic               mul_src_ready,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic               mul_dest_val,
   output logic               mul_dest_ready,
   input  logic [2*WIDTH-1:0] mul_product,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic [LAT_W-1:0]   out_latency,
   output logic               busy,
   output logic               timeout_err
);

   state_t             state;
   logic [LAT_W-1:0]   lat_cnt;
   logic               rst_done;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               capture;
   logic [2*WIDTH-1:0] fifo_head;

   // in_ready is held low until the first cycle after reset is released
   assign in_ready       = rst_done && !fifo_full;
   assign push           = in_valid && in_ready;
   assign mul_src_val    = (state == ISSUE);
   assign pop            = mul_src_val && mul_src_ready;
   assign mul_dest_ready = (state == WAIT) && (!out_valid || out_ready);
   assign capture        = mul_dest_val && mul_dest_ready;
   assign busy           = (state != IDLE) || !fifo_empty;
   assign mul_a          = fifo_head[2*WIDTH-1:WIDTH];
   assign mul_b          = fifo_head[WIDTH-1:0];

   sync_fifo #(
      .DW    (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({in_a, in_b}),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Marks the end of reset so the upstream side opens one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         rst_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
      end
   end

   // Issue/wait control with latency counter and sticky timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         lat_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (mul_src_ready) begin
                  lat_cnt <= '0;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (capture) begin
                  state <= IDLE;
               end else if (lat_cnt == LAT_W'(TIMEOUT - 1)) begin
                  // Next count would reach TIMEOUT without a result
                  timeout_err <= 1'b1;
                  state       <= ERR;
               end else if (lat_cnt != '1) begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            ERR: begin
               state <= ERR;
            end
         endcase
      end
   end

   // Result register: a capture wins over a same-cycle downstream accept
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_product <= '0;
         out_latency <= '0;
      end else if (capture) begin
         out_valid   <= 1'b1;
         out_product <= mul_product;
         out_latency <= lat_cnt + 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_client.sv
// Directed bench for mul_client with a behavioural multiplier responder.
module tb_mul_client;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        mul_src_val;
   logic        mul_src_ready;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic        mul_dest_val;
   logic        mul_dest_ready;
   logic [31:0] mul_product;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_product;
   logic [7:0]  out_latency;
   logic        busy;
   logic        timeout_err;

   int errors = 0;
   int checks = 0;
   int resp_delay;
   logic resp_en;

   mul_client #(
      .WIDTH   (16),
      .DEPTH   (4),
      .LAT_W   (8),
      .TIMEOUT (20)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_a           (in_a),
      .in_b           (in_b),
      .mul_src_val    (mul_src_val),
      .mul_src_ready  (mul_src_ready),
      .mul_a          (mul_a),
      .mul_b          (mul_b),
      .mul_dest_val   (mul_dest_val),
      .mul_dest_ready (mul_dest_ready),
      .mul_product    (mul_product),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_product    (out_product),
      .out_latency    (out_latency),
      .busy           (busy),
      .timeout_err    (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] a, input logic [15:0] b);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            tick();
            done = 1'b1;
         end else begin
            n++;
            if (n > 200) begin
               chk("push_accept", 0, 1);
               done = 1'b1;
            end
            tick();
         end
      end
      in_valid = 1'b0;
   endtask

   // Waits for out_valid, then checks; consumes only if out_ready is high
   task automatic expect_out(input string tag, input logic [31:0] exp_p,
                             input bit do_lat, input logic [7:0] exp_lat);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 300) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
         end else begin
            n++;
            tick();
         end
      end
      chk({tag, "_valid"}, seen, 1);
      if (seen) begin
         chk({tag, "_product"}, out_product, exp_p);
         if (do_lat) chk({tag, "_latency"}, out_latency, exp_lat);
         tick();
      end
   endtask

   // Multiplier model: raises dest_val resp_delay cycles after the issue
   // handshake and holds it until accepted.
   initial begin : responder
      logic hs_s;
      logic hs_d;
      logic was_rst;
      logic active;
      int   cnt;
      logic [31:0] prod;
      mul_dest_val = 1'b0;
      mul_product  = '0;
      active = 1'b0;
      cnt    = 0;
      prod   = '0;
      forever begin
         @(negedge clk);
         was_rst = rst;
         hs_s = mul_src_val && mul_src_ready;
         hs_d = mul_dest_val && mul_dest_ready;
         if (hs_s) prod = $signed(mul_a) * $signed(mul_b);
         @(posedge clk);
         #1;
         if (was_rst) begin
            active = 1'b0;
            mul_dest_val = 1'b0;
         end else begin
            if (hs_d) begin
               mul_dest_val = 1'b0;
               active = 1'b0;
            end
            if (hs_s) begin
               active = 1'b1;
               cnt = 0;
            end else if (active && !mul_dest_val) begin
               cnt++;
               if (resp_en && cnt >= resp_delay - 1) begin
                  mul_dest_val = 1'b1;
                  mul_product  = prod;
               end
            end
         end
      end
   end

   initial begin : main
      int n;
      bit hs;
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      mul_src_ready = 1'b1;
      out_ready = 1'b0;
      resp_en = 1'b1;
      resp_delay = 17;
      repeat (3) tick();

      // Reset state
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_src_val", mul_src_val, 0);
      chk("rst_dest_ready", mul_dest_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout_err", timeout_err, 0);
      rst = 1'b0;
      tick();
      chk("in_ready_after_rst", in_ready, 1);

      // Single op, result held until accepted
      push(16'd3, 16'd5);
      expect_out("single", 32'd15, 1'b1, 8'd17);
      repeat (3) tick();
      chk("single_held_valid", out_valid, 1);
      chk("single_held_product", out_product, 32'd15);
      out_ready = 1'b1;
      tick();
      chk("single_consumed", out_valid, 0);
      chk("single_idle_busy", busy, 0);

      // Signed operands pass through unmodified
      resp_delay = 4;
      push(16'hFFFD, 16'd7);
      expect_out("signed", 32'hFFFF_FFEB, 1'b1, 8'd4);

      // FIFO full while the multiplier stalls the issue
      resp_delay = 3;
      mul_src_ready = 1'b0;
      push(16'd1, 16'd1);
      push(16'd2, 16'd2);
      push(16'd3, 16'd3);
      push(16'd4, 16'd4);
      chk("full_in_ready", in_ready, 0);
      chk("full_src_val", mul_src_val, 1);
      fork
         push(16'd5, 16'd5);
      join_none
      repeat (5) tick();
      chk("stall_mul_a", mul_a, 16'd1);
      chk("stall_mul_b", mul_b, 16'd1);
      chk("stall_in_ready", in_ready, 0);
      mul_src_ready = 1'b1;
      expect_out("order1", 32'd1, 1'b1, 8'd3);
      expect_out("order2", 32'd4, 1'b1, 8'd3);
      expect_out("order3", 32'd9, 1'b1, 8'd3);
      expect_out("order4", 32'd16, 1'b1, 8'd3);
      expect_out("order5", 32'd25, 1'b1, 8'd3);
      wait fork;

      // Output backpressure
      out_ready = 1'b0;
      push(16'd2, 16'd3);
      push(16'd4, 16'd5);
      expect_out("bp_first", 32'd6, 1'b0, 8'd0);
      n = 0;
      while (!mul_dest_val && n < 100) begin
         tick();
         n++;
      end
      chk("bp_second_dest_val", mul_dest_val, 1);
      chk("bp_dest_ready_low", mul_dest_ready, 0);
      repeat (3) tick();
      chk("bp_dest_ready_still_low", mul_dest_ready, 0);
      chk("bp_first_kept", out_product, 32'd6);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_dest_ready_release", mul_dest_ready, 1);
      tick();
      chk("bp_swap_valid", out_valid, 1);
      chk("bp_second_product", out_product, 32'd20);
      tick();
      chk("bp_drained", out_valid, 0);

      // Timeout when the multiplier never answers
      resp_en = 1'b0;
      push(16'd7, 16'd7);
      n = 0;
      hs = 1'b0;
      while (!hs && n < 100) begin
         @(negedge clk);
         hs = mul_src_val && mul_src_ready;
         tick();
         n++;
      end
      chk("to_issued", hs, 1);
      repeat (19) tick();
      chk("to_not_yet", timeout_err, 0);
      tick();
      chk("to_flag", timeout_err, 1);
      repeat (2) tick();
      chk("to_src_val_low", mul_src_val, 0);
      chk("to_dest_ready_low", mul_dest_ready, 0);
      push(16'd8, 16'd8);
      tick();
      chk("to_err_no_issue", mul_src_val, 0);
      chk("to_err_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("to_rst_clear", timeout_err, 0);
      chk("to_rst_busy", busy, 0);
      tick();
      chk("to_rst_in_ready", in_ready, 1);

      // Reset in the middle of WAIT with entries queued and a result pending
      resp_en = 1'b1;
      resp_delay = 3;
      out_ready = 1'b0;
      push(16'd9, 16'd9);
      expect_out("pend", 32'd81, 1'b0, 8'd0);
      resp_en = 1'b0;
      push(16'd1, 16'd2);
      push(16'd3, 16'd4);
      push(16'd5, 16'd6);
      repeat (2) tick();
      chk("mid_busy", busy, 1);
      chk("mid_out_valid", out_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_src_val", mul_src_val, 0);
      chk("mid_rst_busy", busy, 0);
      tick();
      chk("mid_rst_in_ready", in_ready, 1);
      repeat (2) tick();
      chk("mid_rst_queue_gone", mul_src_val, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
